// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs -- shared machine-wide definitions for the out-of-order core.
//
// Provides the superscalar width, physical register file and ROB sizes, and
// the physical-tag type used by the rename stage. The map table derives its
// parameter defaults from here.
// -----------------------------------------------------------------------------
package sys_defs;

    // Superscalar width: number of rename lanes per cycle.
    localparam int N = 3;

    // Physical register file and reorder buffer sizes (R10K-style renaming).
    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int ROB_SZ           = 32;

    // Physical register tag.
    localparam int PHYS_TAG_BITS = $clog2(PHYS_REG_SZ_R10K);
    typedef logic [PHYS_TAG_BITS-1:0] PHYS_TAG;

endpackage : sys_defs

// File: rtl/map_table_read_port.sv
// -----------------------------------------------------------------------------
// map_table_read_port -- one combinational lookup into the rename map table.
//
// Returns the physical tag and ready bit for one architectural register as
// seen by rename lane LANE. Older lanes (index < LANE) renaming the same
// register this cycle override the table. AR0 and out-of-range indices always
// read as tag 0 / ready 1.
//
// Optional feature: when MAP_TABLE_CDB_BYPASS_EN is defined, a table hit whose
// tag is being broadcast on the CDB this cycle reports ready immediately.
//
// Ports:
//   ar         in   AW               architectural register to look up
//   map        in   ARCH_COUNT x TW  registered map table
//   rdy        in   ARCH_COUNT       registered ready bits
//   new_ar     in   LANES x AW       rename destinations (already range-checked)
//   new_pr     in   LANES x TW       rename physical tags
//   bypass_en  in   1                enable the intra-bundle bypass
//   cdb_en     in   1                enable the CDB ready bypass (macro only)
//   cdb_valid  in   LANES            CDB broadcast valid (macro only)
//   cdb_tag    in   LANES x TW       CDB broadcast tags (macro only)
//   tag        out  TW               resulting physical tag
//   ready      out  1                resulting ready bit
// -----------------------------------------------------------------------------
module map_table_read_port #(
    parameter int ARCH_COUNT = 32,
    parameter int AW         = 5,
    parameter int TW         = 6,
    parameter int LANES      = 3,
    parameter int LANE       = 0
) (
    input  logic [AW-1:0]                 ar,
    input  logic [ARCH_COUNT-1:0][TW-1:0] map,
    input  logic [ARCH_COUNT-1:0]         rdy,
    input  logic [LANES-1:0][AW-1:0]      new_ar,
    input  logic [LANES-1:0][TW-1:0]      new_pr,
    input  logic                          bypass_en,
`ifdef MAP_TABLE_CDB_BYPASS_EN
    input  logic                          cdb_en,
    input  logic [LANES-1:0]              cdb_valid,
    input  logic [LANES-1:0][TW-1:0]      cdb_tag,
`endif
    output logic [TW-1:0]                 tag,
    output logic                          ready
);

    localparam logic [AW:0] AR_LIMIT = (AW+1)'(ARCH_COUNT);

    logic [AW-1:0] ar_n;
    logic          byp_hit;
    logic [TW-1:0] byp_tag;

    // Out-of-range indices alias to AR0.
    assign ar_n = ({1'b0, ar} < AR_LIMIT) ? ar : '0;

    // Youngest older lane renaming the same register wins: the ascending scan
    // leaves the highest matching j in byp_tag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // branch, otherwise a path that skips the assignment infers a latch.
        byp_hit = 1'b0;
        byp_tag = '0;
        if (bypass_en && ar_n != '0) begin
            for (int j = 0; j < LANES; j++) begin
                if (j < LANE && new_ar[j] == ar_n) begin
                    byp_hit = 1'b1;
                    byp_tag = new_pr[j];
                end
            end
        end
    end

    always_comb begin
        tag   = '0;
        ready = 1'b1;
        if (ar_n != '0) begin
            if (byp_hit) begin
                tag   = byp_tag;
                ready = 1'b0;
            end else begin
                tag   = map[ar_n];
                ready = rdy[ar_n];
`ifdef MAP_TABLE_CDB_BYPASS_EN
                if (cdb_en) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (cdb_valid[k] && cdb_tag[k] == map[ar_n]) begin
                            ready = 1'b1;
                        end
                    end
                end
`endif
            end
        end
    end

endmodule : map_table_read_port

// File: rtl/map_table.sv
// -----------------------------------------------------------------------------
// map_table -- register rename map table (architectural -> physical tag).
//
// Holds one physical tag and one ready bit per architectural register. Each
// cycle up to N lanes rename a destination register, CDB broadcasts mark
// matching entries ready, and branch-mispredict recovery reloads the whole
// table from the retirement map. All lookups are combinational on the
// pre-edge state, with an intra-bundle bypass so lane i sees renames from
// older lanes of the same bundle.
//
// Optional feature macro: MAP_TABLE_CDB_BYPASS_EN -- when defined, lookups
// whose tag is on the CDB this cycle report ready in the same cycle; when
// undefined the wakeup becomes visible the cycle after the broadcast.
//
// Ports:
//   clock            in   1                sole clock
//   reset            in   1                asynchronous, active-high
//   archi_maptable   in   ARCH_COUNT x TW  retirement map used for recovery
//   BPRecoverEN      in   1                branch-mispredict recovery request
//   cdb_valid        in   N                CDB broadcast valid per lane
//   cdb_tag          in   N x TW           CDB broadcast tags
//   maptable_new_pr  in   N x TW           new physical tag per rename lane
//   maptable_new_ar  in   N x AW           destination AR per lane (0 = none)
//   reg1_ar, reg2_ar in   N x AW           source AR lookups
//   reg1_tag/reg2_tag out N x TW           source tags
//   reg1_ready/reg2_ready out N            source ready bits
//   told_ar          in   N x AW           destination AR for previous mapping
//   Told_out         out  N x TW           previous physical tag of told_ar
// -----------------------------------------------------------------------------
module map_table #(
    parameter  int ARCH_COUNT = sys_defs::PHYS_REG_SZ_R10K - sys_defs::ROB_SZ,
    parameter  int PHYS_REGS  = sys_defs::PHYS_REG_SZ_R10K,
    parameter  int N          = sys_defs::N,
    localparam int AW         = $clog2(ARCH_COUNT),
    localparam int TW         = $clog2(PHYS_REGS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ARCH_COUNT-1:0][TW-1:0] archi_maptable,
    input  logic                          BPRecoverEN,
    input  logic [N-1:0]                  cdb_valid,
    input  logic [N-1:0][TW-1:0]          cdb_tag,
    input  logic [N-1:0][TW-1:0]          maptable_new_pr,
    input  logic [N-1:0][AW-1:0]          maptable_new_ar,
    input  logic [N-1:0][AW-1:0]          reg1_ar,
    input  logic [N-1:0][AW-1:0]          reg2_ar,
    output logic [N-1:0][TW-1:0]          reg1_tag,
    output logic [N-1:0][TW-1:0]          reg2_tag,
    output logic [N-1:0]                  reg1_ready,
    output logic [N-1:0]                  reg2_ready,
    input  logic [N-1:0][AW-1:0]          told_ar,
    output logic [N-1:0][TW-1:0]          Told_out
);

    localparam logic [AW:0] AR_LIMIT = (AW+1)'(ARCH_COUNT);

    logic [ARCH_COUNT-1:0][TW-1:0] map;
    logic [ARCH_COUNT-1:0]         rdy;
    logic [N-1:0][AW-1:0]          new_ar_n;
    logic                          bypass_en;
    logic [N-1:0]                  told_ready_unused;

    // Renames to out-of-range registers alias to AR0 and are therefore dropped.
    always_comb begin
        new_ar_n = '0;
        for (int i = 0; i < N; i++) begin
            new_ar_n[i] = ({1'b0, maptable_new_ar[i]} < AR_LIMIT) ? maptable_new_ar[i] : '0;
        end
    end

    // During recovery and while reset is held the lookups must show the raw
    // table, so the bundle bypass is suppressed.
    assign bypass_en = ~BPRecoverEN & ~reset;

`ifdef MAP_TABLE_CDB_BYPASS_EN
    logic cdb_en;
    assign cdb_en = ~reset;
`endif

    // NOTE: the table is a small flop array rather than a memory macro, so
    // every entry can take the identity mapping on asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH_COUNT; a++) begin
                map[a] <= TW'(a);
            end
            rdy <= '1;
        end else if (BPRecoverEN) begin
            map <= archi_maptable;
            rdy <= '1;
        end else begin
            // NOTE: non-blocking updates to the same entry resolve to the last
            // one executed, so wakeups come first, then renames in ascending
            // lane order: rename beats wakeup and the highest lane wins.
            for (int a = 1; a < ARCH_COUNT; a++) begin
                for (int k = 0; k < N; k++) begin
                    if (cdb_valid[k] && map[a] == cdb_tag[k]) begin
                        rdy[a] <= 1'b1;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (new_ar_n[i] != '0) begin
                    map[new_ar_n[i]] <= maptable_new_pr[i];
                    rdy[new_ar_n[i]] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        map_table_read_port #(
            .ARCH_COUNT(ARCH_COUNT), .AW(AW), .TW(TW), .LANES(N), .LANE(i)
        ) u_reg1 (
            .ar        (reg1_ar[i]),
            .map       (map),
            .rdy       (rdy),
            .new_ar    (new_ar_n),
            .new_pr    (maptable_new_pr),
            .bypass_en (bypass_en),
`ifdef MAP_TABLE_CDB_BYPASS_EN
            .cdb_en    (cdb_en),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
`endif
            .tag       (reg1_tag[i]),
            .ready     (reg1_ready[i])
        );

        map_table_read_port #(
            .ARCH_COUNT(ARCH_COUNT), .AW(AW), .TW(TW), .LANES(N), .LANE(i)
        ) u_reg2 (
            .ar        (reg2_ar[i]),
            .map       (map),
            .rdy       (rdy),
            .new_ar    (new_ar_n),
            .new_pr    (maptable_new_pr),
            .bypass_en (bypass_en),
`ifdef MAP_TABLE_CDB_BYPASS_EN
            .cdb_en    (cdb_en),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
`endif
            .tag       (reg2_tag[i]),
            .ready     (reg2_ready[i])
        );

        // The previous-mapping lookup only needs the tag.
        map_table_read_port #(
            .ARCH_COUNT(ARCH_COUNT), .AW(AW), .TW(TW), .LANES(N), .LANE(i)
        ) u_told (
            .ar        (told_ar[i]),
            .map       (map),
            .rdy       (rdy),
            .new_ar    (new_ar_n),
            .new_pr    (maptable_new_pr),
            .bypass_en (bypass_en),
`ifdef MAP_TABLE_CDB_BYPASS_EN
            .cdb_en    (cdb_en),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
`endif
            .tag       (Told_out[i]),
            .ready     (told_ready_unused[i])
        );
    end

endmodule : map_table

// File: tb/tb_map_table.sv
// -----------------------------------------------------------------------------
// tb_map_table -- self-checking bench for map_table.
//
// A behavioural model (plain int arrays plus the lookup/update rules) predicts
// every lookup output each cycle. Directed scenarios cover reset, rename,
// same-bundle chaining, CDB wakeup, recovery and AR0; a randomized phase then
// mixes all of them. Inputs change on the falling edge; outputs are sampled
// 1 time unit later, and the model advances on the rising edge.
// Honours MAP_TABLE_CDB_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_map_table;
    import sys_defs::*;

    localparam int AC = PHYS_REG_SZ_R10K - ROB_SZ;
    localparam int PR = PHYS_REG_SZ_R10K;
    localparam int NL = N;
    localparam int TW = $clog2(PR);
    localparam int AW = $clog2(AC);

    logic                  clock = 1'b0;
    logic                  reset;
    logic [AC-1:0][TW-1:0] archi_maptable;
    logic                  BPRecoverEN;
    logic [NL-1:0]         cdb_valid;
    logic [NL-1:0][TW-1:0] cdb_tag;
    logic [NL-1:0][TW-1:0] maptable_new_pr;
    logic [NL-1:0][AW-1:0] maptable_new_ar;
    logic [NL-1:0][AW-1:0] reg1_ar, reg2_ar, told_ar;
    logic [NL-1:0][TW-1:0] reg1_tag, reg2_tag, Told_out;
    logic [NL-1:0]         reg1_ready, reg2_ready;

    always #5 clock = ~clock;

    map_table #(.ARCH_COUNT(AC), .PHYS_REGS(PR), .N(NL)) dut (
        .clock           (clock),
        .reset           (reset),
        .archi_maptable  (archi_maptable),
        .BPRecoverEN     (BPRecoverEN),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .maptable_new_pr (maptable_new_pr),
        .maptable_new_ar (maptable_new_ar),
        .reg1_ar         (reg1_ar),
        .reg2_ar         (reg2_ar),
        .reg1_tag        (reg1_tag),
        .reg2_tag        (reg2_tag),
        .reg1_ready      (reg1_ready),
        .reg2_ready      (reg2_ready),
        .told_ar         (told_ar),
        .Told_out        (Told_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural register -> physical tag, ready flag.
    int m_map [AC];
    bit m_rdy [AC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < AC; i++) begin
            m_map[i] = i;
            m_rdy[i] = 1'b1;
        end
    endfunction

    // What lane `lane` should see for register `ar` given the current inputs.
    function automatic void ref_lookup(input int lane, input int ar, output int tag, output int rd);
        bit found = 1'b0;
        tag = 0;
        rd  = 1;
        if (ar == 0 || ar >= AC) return;
        if (!BPRecoverEN && !reset) begin
            // nearest older lane renaming this register
            for (int j = lane - 1; j >= 0 && !found; j--) begin
                if (int'(maptable_new_ar[j]) == ar) begin
                    tag   = int'(maptable_new_pr[j]);
                    rd    = 0;
                    found = 1'b1;
                end
            end
        end
        if (!found) begin
            tag = m_map[ar];
            rd  = int'(m_rdy[ar]);
`ifdef MAP_TABLE_CDB_BYPASS_EN
            if (!reset) begin
                for (int k = 0; k < NL; k++) begin
                    if (cdb_valid[k] && int'(cdb_tag[k]) == tag) rd = 1;
                end
            end
`endif
        end
    endfunction

    // Clock edge: recovery reload, else wakeups followed by renames.
    function automatic void model_step();
        if (BPRecoverEN) begin
            for (int i = 0; i < AC; i++) begin
                m_map[i] = int'(archi_maptable[i]);
                m_rdy[i] = 1'b1;
            end
        end else begin
            for (int a = 0; a < AC; a++) begin
                for (int k = 0; k < NL; k++) begin
                    if (cdb_valid[k] && int'(cdb_tag[k]) == m_map[a]) m_rdy[a] = 1'b1;
                end
            end
            for (int l = 0; l < NL; l++) begin
                int ar = int'(maptable_new_ar[l]);
                if (ar != 0 && ar < AC) begin
                    m_map[ar] = int'(maptable_new_pr[l]);
                    m_rdy[ar] = 1'b0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        int t, r;
        for (int i = 0; i < NL; i++) begin
            ref_lookup(i, int'(reg1_ar[i]), t, r);
            check($sformatf("reg1_tag[%0d]", i), 32'(reg1_tag[i]), 32'(t));
            check($sformatf("reg1_ready[%0d]", i), 32'(reg1_ready[i]), 32'(r));
            ref_lookup(i, int'(reg2_ar[i]), t, r);
            check($sformatf("reg2_tag[%0d]", i), 32'(reg2_tag[i]), 32'(t));
            check($sformatf("reg2_ready[%0d]", i), 32'(reg2_ready[i]), 32'(r));
            ref_lookup(i, int'(told_ar[i]), t, r);
            check($sformatf("Told_out[%0d]", i), 32'(Told_out[i]), 32'(t));
        end
    endtask

    task automatic clear_inputs();
        BPRecoverEN     = 1'b0;
        cdb_valid       = '0;
        cdb_tag         = '0;
        maptable_new_pr = '0;
        maptable_new_ar = '0;
        reg1_ar         = '0;
        reg2_ar         = '0;
        told_ar         = '0;
        for (int i = 0; i < AC; i++) archi_maptable[i] = TW'(i);
    endtask

    task automatic begin_cycle();
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
    endtask

    task automatic randomize_writes();
        for (int l = 0; l < NL; l++) begin
            maptable_new_ar[l] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 7));
            maptable_new_pr[l] = TW'($urandom_range(0, PR - 1));
            cdb_valid[l]       = 1'($urandom_range(0, 1));
            cdb_tag[l]         = ($urandom_range(0, 1) == 1) ? TW'(m_map[$urandom_range(1, 9)])
                                                            : TW'($urandom_range(0, PR - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();

        // Reset held: table is identity, write inputs and bypass ignored.
        begin_cycle();
        randomize_writes();
        for (int l = 0; l < NL; l++) begin
            reg1_ar[l] = AW'(l + 1);
            told_ar[l] = AW'(l + 1);
            maptable_new_ar[l] = AW'(1);
        end
        settle();
        for (int l = 0; l < NL; l++) check($sformatf("rst_tag[%0d]", l), 32'(reg1_tag[l]), 32'(l + 1));
        @(posedge clock);

        // Identity lookup after reset release.
        begin_cycle();
        reset = 1'b0;
        for (int l = 0; l < NL; l++) begin
            reg1_ar[l] = AW'(l + 1);
            told_ar[l] = AW'(l + 1);
        end
        settle();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("init_tag[%0d]", l), 32'(reg1_tag[l]), 32'(l + 1));
            check($sformatf("init_told[%0d]", l), 32'(Told_out[l]), 32'(l + 1));
        end
        check("init_ready", 32'(reg1_ready), 32'(3'b111));
        tick();

        // Rename AR1..3 -> 40..42.
        begin_cycle();
        for (int l = 0; l < NL; l++) begin
            maptable_new_ar[l] = AW'(l + 1);
            maptable_new_pr[l] = TW'(40 + l);
            told_ar[l]         = AW'(l + 1);
        end
        settle();
        tick();
        begin_cycle();
        for (int l = 0; l < NL; l++) begin
            reg1_ar[l] = AW'(l + 1);
            told_ar[l] = AW'(l + 1);
        end
        settle();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("ren_tag[%0d]", l), 32'(reg1_tag[l]), 32'(40 + l));
            check($sformatf("ren_told[%0d]", l), 32'(Told_out[l]), 32'(40 + l));
        end
        check("ren_ready", 32'(reg1_ready), 32'(3'b000));
        tick();

        // Same-bundle chain on AR5.
        begin_cycle();
        for (int l = 0; l < NL; l++) begin
            maptable_new_ar[l] = AW'(5);
            maptable_new_pr[l] = TW'(40 + l);
            told_ar[l]         = AW'(5);
        end
        settle();
        check("chain_told0", 32'(Told_out[0]), 32'(5));
        check("chain_told1", 32'(Told_out[1]), 32'(40));
        check("chain_told2", 32'(Told_out[2]), 32'(41));
        tick();
        begin_cycle();
        reg1_ar[0] = AW'(5);
        settle();
        check("chain_final", 32'(reg1_tag[0]), 32'(42));
        tick();

        // AR4 -> 40 not ready, then CDB wakeup of tag 40.
        begin_cycle();
        maptable_new_ar[0] = AW'(4);
        maptable_new_pr[0] = TW'(40);
        settle();
        tick();
        begin_cycle();
        cdb_valid[0] = 1'b1;
        cdb_tag[0]   = TW'(40);
        reg1_ar[0]   = AW'(4);
        settle();
`ifdef MAP_TABLE_CDB_BYPASS_EN
        check("cdb_same_cycle", 32'(reg1_ready[0]), 32'(1));
`else
        check("cdb_same_cycle", 32'(reg1_ready[0]), 32'(0));
`endif
        tick();
        begin_cycle();
        reg1_ar[0] = AW'(4);
        settle();
        check("cdb_next_cycle", 32'(reg1_ready[0]), 32'(1));
        tick();

        // Recovery with a concurrent rename of AR7.
        begin_cycle();
        BPRecoverEN = 1'b1;
        for (int i = 0; i < AC; i++) archi_maptable[i] = TW'(i + 10);
        maptable_new_ar[0] = AW'(7);
        maptable_new_pr[0] = TW'(55);
        reg1_ar[1] = AW'(7);
        settle();
        tick();
        begin_cycle();
        reg1_ar[0] = AW'(7);
        settle();
        check("recover_tag", 32'(reg1_tag[0]), 32'(17));
        check("recover_ready", 32'(reg1_ready[0]), 32'(1));
        tick();

        // AR0 lookup and rename.
        begin_cycle();
        maptable_new_ar[0] = '0;
        maptable_new_pr[0] = TW'(50);
        reg1_ar[1] = '0;
        told_ar[2] = '0;
        settle();
        check("ar0_tag", 32'(reg1_tag[1]), 32'(0));
        check("ar0_ready", 32'(reg1_ready[1]), 32'(1));
        check("ar0_told", 32'(Told_out[2]), 32'(0));
        tick();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            begin_cycle();
            BPRecoverEN = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < AC; i++) archi_maptable[i] = TW'($urandom_range(0, PR - 1));
            randomize_writes();
            for (int l = 0; l < NL; l++) begin
                reg1_ar[l] = AW'($urandom_range(0, 9));
                reg2_ar[l] = AW'($urandom_range(0, 9));
                told_ar[l] = AW'($urandom_range(0, 9));
            end
            settle();
            tick();
        end

        // Asynchronous reset between clock edges.
        begin_cycle();
        randomize_writes();
        for (int l = 0; l < NL; l++) begin
            reg1_ar[l] = AW'(l + 1);
            reg2_ar[l] = AW'(l + 4);
            told_ar[l] = AW'(l + 1);
        end
        #1;
        reset = 1'b1;
        model_reset();
        settle();
        for (int l = 0; l < NL; l++) begin
            check($sformatf("async_rst_tag[%0d]", l), 32'(reg1_tag[l]), 32'(l + 1));
            check($sformatf("async_rst_told[%0d]", l), 32'(Told_out[l]), 32'(l + 1));
        end
        check("async_rst_ready", 32'(reg2_ready), 32'(3'b111));
        @(posedge clock);
        @(negedge clock);
        settle();
        reset = 1'b0;
        clear_inputs();
        reg1_ar[0] = AW'(9);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_map_table
